control_unit: RTL and testbench



---
 rtl/control_unit_if.sv | 31 +++
 rtl/control_unit.sv | 109 ++++++++++
 tb/tb_control_unit.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Control-side bus of the sequencer: ROM fetch, datapath strobes and flag returns.
// The master modport belongs to control_unit; the slave modport to the ROM/datapath side.
interface control_unit_if;
  logic [15:0] instr;
  logic        pause_req;
  logic        step;
  logic        alu_zero;
  logic        alu_carry;
  logic [7:0]  pc;
  logic        alu_en;
  logic [2:0]  alu_opcode;
  logic [7:0]  imm_value;
  logic [3:0]  write_addr;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic        write_en;
  logic        cpu_paused;
  logic        halted;

  modport master (
    input  instr, pause_req, step, alu_zero, alu_carry,
    output pc, alu_en, alu_opcode, imm_value, write_addr, ra_addr, rb_addr,
           write_en, cpu_paused, halted
  );

  modport slave (
    output instr, pause_req, step, alu_zero, alu_carry,
    input  pc, alu_en, alu_opcode, imm_value, write_addr, ra_addr, rb_addr,
           write_en, cpu_paused, halted
  );
endinterface

// File: rtl/control_unit.sv
// Two-cycle fetch/execute sequencer and decoder driving the datapath control ports.
// Z/C are latched from the datapath at the end of every ALU execute for later branches.
module control_unit (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master ctrl
);

  // state    | meaning
  // ST_FETCH | latch ROM word into IR, or hold while paused without a step
  // ST_EXEC  | issue strobes for IR, update pc and flags
  // ST_HALT  | stopped after HALT, left only through rst
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  pc_q, pc_d;
  logic        z_q, z_d;
  logic        c_q, c_d;

  logic [2:0]  cls;
  logic        is_alu, is_ldi, is_jmp, is_jz, is_jc, is_halt;
  logic        br_taken, hold;
  logic        we_raw, ae_raw, paused, halted;

  assign cls      = ir_q[14:12];
  assign is_alu   = ir_q[15];
  assign is_ldi   = !ir_q[15] && (cls == 3'b001);
  assign is_jmp   = !ir_q[15] && (cls == 3'b010);
  assign is_jz    = !ir_q[15] && (cls == 3'b011);
  assign is_jc    = !ir_q[15] && (cls == 3'b100);
  assign is_halt  = !ir_q[15] && (cls == 3'b101);
  assign br_taken = is_jmp || (is_jz && z_q) || (is_jc && c_q);
  assign hold     = ctrl.pause_req && !ctrl.step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= 16'h0000;
      pc_q    <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    z_d     = z_q;
    c_d     = c_q;
    we_raw  = 1'b0;
    ae_raw  = 1'b0;
    paused  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        paused = hold;
        if (!hold) begin
          ir_d    = ctrl.instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        we_raw = is_alu || is_ldi;
        ae_raw = is_alu;
        if (is_alu) begin
          z_d = ctrl.alu_zero;
          c_d = ctrl.alu_carry;
        end
        // HALT keeps pc on its own address so the stop point stays visible
        if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          pc_d    = br_taken ? ir_q[7:0] : pc_q + 8'd1;
        end
      end
      ST_HALT: begin
        paused = 1'b1;
        halted = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes are gated by rst so a reset landing in EXEC commits nothing.
  assign ctrl.write_en   = we_raw && !rst;
  assign ctrl.alu_en     = ae_raw && !rst;
  assign ctrl.cpu_paused = paused;
  assign ctrl.halted     = halted;
  assign ctrl.pc         = pc_q;
  assign ctrl.alu_opcode = ir_q[14:12];
  assign ctrl.write_addr = ir_q[11:8];
  assign ctrl.ra_addr    = is_alu ? ir_q[7:4] : 4'h0;
  assign ctrl.rb_addr    = is_alu ? ir_q[3:0] : 4'h0;
  assign ctrl.imm_value  = ir_q[7:0];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: combinational ROM, a small datapath, and an
// instruction-level reference model compared at every fetch/execute.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dp_clr = 1'b1;

  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  logic [15:0] rom [256];
  logic [7:0]  dp_rf [16];
  logic [9:0]  alu_out;
  int          sub_wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_rf [16];
  logic [7:0] ref_pc;
  logic       ref_z, ref_c, ref_halted;

  // datapath ALU: {carry, zero, result}
  function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int         s;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    r = 8'h00;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  assign bus.instr     = rom[bus.pc];
  assign alu_out       = alu_f(bus.alu_opcode, dp_rf[bus.ra_addr], dp_rf[bus.rb_addr]);
  assign bus.alu_zero  = alu_out[8];
  assign bus.alu_carry = alu_out[9];

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 16; i++) dp_rf[i] <= 8'h00;
      sub_wr_cnt <= 0;
    end else if (bus.write_en) begin
      if (bus.write_addr != 4'h0)
        dp_rf[bus.write_addr] <= bus.alu_en ? alu_out[7:0] : bus.imm_value;
      if (bus.alu_en && bus.alu_opcode == 3'd1) sub_wr_cnt <= sub_wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic ref_init(input bit clr_rf);
    ref_pc = 8'h00;
    ref_z = 1'b0;
    ref_c = 1'b0;
    ref_halted = 1'b0;
    if (clr_rf) for (int i = 0; i < 16; i++) ref_rf[i] = 8'h00;
  endtask

  task automatic ref_step();
    logic [15:0] w;
    logic [9:0]  a;
    w = rom[ref_pc];
    if (w[15]) begin
      a = alu_f(w[14:12], ref_rf[w[7:4]], ref_rf[w[3:0]]);
      if (w[11:8] != 4'h0) ref_rf[w[11:8]] = a[7:0];
      ref_z = a[8];
      ref_c = a[9];
      ref_pc = ref_pc + 8'd1;
    end else begin
      case (w[14:12])
        3'd1: begin
          if (w[11:8] != 4'h0) ref_rf[w[11:8]] = w[7:0];
          ref_pc = ref_pc + 8'd1;
        end
        3'd2: ref_pc = w[7:0];
        3'd3: ref_pc = ref_z ? w[7:0] : ref_pc + 8'd1;
        3'd4: ref_pc = ref_c ? w[7:0] : ref_pc + 8'd1;
        3'd5: ref_halted = 1'b1;
        default: ref_pc = ref_pc + 8'd1;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dp_clr = 1'b1;
    bus.pause_req = 1'b0;
    bus.step = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_pc", 32'(bus.pc), 32'h0);
    check_eq("rst_we", 32'(bus.write_en), 32'h0);
    check_eq("rst_alu_en", 32'(bus.alu_en), 32'h0);
    check_eq("rst_halted", 32'(bus.halted), 32'h0);
    check_eq("rst_paused_lo", 32'(bus.cpu_paused), 32'h0);
    bus.pause_req = 1'b1;
    #1;
    check_eq("rst_paused_hi", 32'(bus.cpu_paused), 32'h1);
    bus.pause_req = 1'b0;
    rst = 1'b0;
    dp_clr = 1'b0;
    ref_init(1'b1);
    #1;
  endtask

  // Entered between negedge and posedge of a FETCH cycle.
  task automatic run_instrs(input int n);
    logic [15:0] w;
    logic [7:0]  hpc;
    for (int i = 0; i < n && !ref_halted; i++) begin
      w = rom[ref_pc];
      check_eq("fetch_pc", 32'(bus.pc), 32'(ref_pc));
      check_eq("fetch_we", 32'(bus.write_en), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check_eq("exec_we", 32'(bus.write_en), 32'(w[15] || (w[15:12] == 4'h1)));
      check_eq("exec_alu_en", 32'(bus.alu_en), 32'(w[15]));
      check_eq("exec_wa", 32'(bus.write_addr), 32'(w[11:8]));
      check_eq("exec_ra", 32'(bus.ra_addr), w[15] ? 32'(w[7:4]) : 32'h0);
      check_eq("exec_rb", 32'(bus.rb_addr), w[15] ? 32'(w[3:0]) : 32'h0);
      check_eq("exec_imm", 32'(bus.imm_value), 32'(w[7:0]));
      check_eq("exec_op", 32'(bus.alu_opcode), 32'(w[14:12]));
      @(posedge clk);
      ref_step();
      @(negedge clk);
    end
    if (ref_halted) begin
      hpc = ref_pc;
      check_eq("halt_flag", 32'(bus.halted), 32'h1);
      check_eq("halt_paused", 32'(bus.cpu_paused), 32'h1);
      check_eq("halt_pc", 32'(bus.pc), 32'(hpc));
      repeat (3) @(negedge clk);
      check_eq("halt_pc_hold", 32'(bus.pc), 32'(hpc));
      check_eq("halt_we", 32'(bus.write_en), 32'h0);
    end
  endtask

  task automatic check_rf(input string tag);
    for (int i = 1; i < 16; i++)
      check_eq($sformatf("%s_r%0d", tag, i), 32'(dp_rf[i]), 32'(ref_rf[i]));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic random_rom();
    logic [15:0] w;
    int          k;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      k = $urandom_range(0, 99);
      if (k < 40)      w[15] = 1'b1;
      else if (k < 65) w[15:12] = 4'h1;
      else if (k < 72) w[15:12] = 4'h2;
      else if (k < 80) w[15:12] = 4'h3;
      else if (k < 88) w[15:12] = 4'h4;
      else if (k < 94) w[15:12] = (k < 90) ? 4'h0 : ((k < 92) ? 4'h6 : 4'h7);
      else             w[15:12] = 4'h5;
      rom[i] = w;
    end
  endtask

  initial begin
    bus.pause_req = 1'b0;
    bus.step = 1'b0;
    clear_rom();

    // LDI then ADD
    rom[0] = 16'h1105; rom[1] = 16'h1203; rom[2] = 16'h8312; rom[3] = 16'h5000;
    do_reset();
    run_instrs(10);
    check_eq("ldi_add_r3", 32'(dp_rf[3]), 32'h08);
    check_eq("ldi_add_pc", 32'(bus.pc), 32'h03);
    check_rf("ldi_add");

    // countdown loop
    clear_rom();
    rom[0] = 16'h1103; rom[1] = 16'h1201; rom[2] = 16'h9112;
    rom[3] = 16'h3010; rom[4] = 16'h2002; rom[16] = 16'h5000;
    do_reset();
    run_instrs(30);
    check_eq("loop_sub_writes", 32'(sub_wr_cnt), 32'd3);
    check_eq("loop_pc", 32'(bus.pc), 32'h10);

    // JC taken (C=1, Z=1) and fall-through
    clear_rom();
    rom[0] = 16'h11FF; rom[1] = 16'h1201; rom[2] = 16'h8312; rom[3] = 16'h4020;
    rom[4] = 16'h5000; rom[32] = 16'h3030; rom[33] = 16'h5000; rom[48] = 16'h5000;
    do_reset();
    run_instrs(10);
    check_eq("jc_taken_pc", 32'(bus.pc), 32'h30);
    rom[0] = 16'h1101;
    do_reset();
    run_instrs(10);
    check_eq("jc_fall_pc", 32'(bus.pc), 32'h04);
    check_eq("jc_fall_r3", 32'(dp_rf[3]), 32'h02);

    // pause and step
    clear_rom();
    rom[0] = 16'h1105; rom[1] = 16'h1203; rom[2] = 16'h8312; rom[3] = 16'h9412;
    rom[4] = 16'hC512; rom[5] = 16'hE610; rom[6] = 16'hB712; rom[7] = 16'h5000;
    do_reset();
    run_instrs(2);
    bus.pause_req = 1'b1;
    #1;
    check_eq("pause_paused", 32'(bus.cpu_paused), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("pause_pc", 32'(bus.pc), 32'h02);
      check_eq("pause_we", 32'(bus.write_en), 32'h0);
      check_eq("pause_flag", 32'(bus.cpu_paused), 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      #1;
      check_eq("step_unpaused", 32'(bus.cpu_paused), 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus.step = 1'b0;
      #1;
      check_eq("step_exec_we", 32'(bus.write_en), 32'h1);
      @(posedge clk);
      ref_step();
      @(negedge clk);
      #1;
      check_eq("step_pc", 32'(bus.pc), 32'(ref_pc));
      check_eq("step_repaused", 32'(bus.cpu_paused), 32'h1);
    end
    check_eq("step_total_pc", 32'(bus.pc), 32'h05);
    bus.pause_req = 1'b0;
    #1;
    run_instrs(20);
    check_rf("pause");

    // pc wrap
    clear_rom();
    rom[0] = 16'h20FE;
    do_reset();
    run_instrs(1);
    check_eq("wrap_pc_fe", 32'(bus.pc), 32'hFE);
    rom[0] = 16'h5000;
    run_instrs(1);
    check_eq("wrap_pc_ff", 32'(bus.pc), 32'hFF);
    run_instrs(1);
    check_eq("wrap_pc_00", 32'(bus.pc), 32'h00);
    run_instrs(3);
    check_eq("wrap_halted", 32'(bus.halted), 32'h1);
    check_eq("wrap_halt_pc", 32'(bus.pc), 32'h00);

    // reset during EXEC of LDI r4,0xAA
    clear_rom();
    rom[0] = 16'h14AA; rom[1] = 16'h5000;
    do_reset();
    @(posedge clk);
    @(negedge clk);
    check_eq("rx_exec_we", 32'(bus.write_en), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rx_we_gated", 32'(bus.write_en), 32'h0);
    check_eq("rx_alu_gated", 32'(bus.alu_en), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rx_r4", 32'(dp_rf[4]), 32'h00);
    check_eq("rx_pc", 32'(bus.pc), 32'h00);
    check_eq("rx_we", 32'(bus.write_en), 32'h0);
    check_eq("rx_halted", 32'(bus.halted), 32'h0);
    check_eq("rx_paused", 32'(bus.cpu_paused), 32'h0);
    rst = 1'b0;
    ref_init(1'b0);
    #1;
    run_instrs(5);
    check_eq("rx_r4_after", 32'(dp_rf[4]), 32'hAA);

    // random programs
    for (int t = 0; t < 6; t++) begin
      random_rom();
      do_reset();
      run_instrs(80);
      check_rf($sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
